// File: rtl/jt12_interp_lin_pkg.sv
// Shared jt12 constants and types for the interpolator feeding the sigma-delta DAC.
// The DAC wrapper and the interpolator both take their ratio default from here.
package jt12_interp_lin_pkg;

    localparam int JT12_INTERP_RW = 5;

    typedef enum logic {
        HOLD = 1'b0,
        RAMP = 1'b1
    } interp_state_e;

endpackage

// File: rtl/jt12_interp_lin.sv
// Linear interpolator: ramps from the current output to each strobed target over
// 2^rate_w clocks and emits one sample per clock for the sigma-delta DAC.
module jt12_interp_lin
    import jt12_interp_lin_pkg::*;
#(
    parameter int width  = 12,
    parameter int rate_w = JT12_INTERP_RW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] din,
    input  logic             din_valid,
    output logic [width-1:0] dout,
    output logic             busy,
    output logic             early
);

    localparam int AW = width + 1 + rate_w;
    localparam int SW = width + 1;
    localparam logic [rate_w-1:0] CNT_ONE = rate_w'(1);

    logic [AW-1:0]     acc_q, acc_d;
    logic [SW-1:0]     step_q, step_d;
    logic [rate_w-1:0] cnt_q, cnt_d;
    interp_state_e     state_q, state_d;
    logic              early_q, early_d;

    logic [SW-1:0] step_new;
    logic [AW-1:0] acc_base;

    // The extra integer bit makes din - dout impossible to overflow.
    assign step_new = {din[width-1], din} - {dout[width-1], dout};
    // Restart point: current integer output with the fraction dropped.
    assign acc_base = {dout[width-1], dout, {rate_w{1'b0}}};

    always_comb begin
        acc_d   = acc_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        early_d = 1'b0;
        if (din_valid) begin
            step_d  = step_new;
            acc_d   = acc_base + {{rate_w{step_new[SW-1]}}, step_new};
            cnt_d   = '1;
            state_d = RAMP;
            early_d = (state_q == RAMP);
        end else if (state_q == RAMP) begin
            acc_d = acc_q + {{rate_w{step_q[SW-1]}}, step_q};
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                state_d = HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            state_q <= HOLD;
            early_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            early_q <= early_d;
        end
    end

    // Integer part is the floor because the accumulator is two's complement.
    assign dout  = acc_q[rate_w +: width];
    assign busy  = (state_q == RAMP);
    assign early = early_q;

endmodule

// File: tb/tb_jt12_interp_lin.sv
// Bench for jt12_interp_lin: directed literal checks plus a random run, with a
// convex-combination model compared against two instances on every clock.
module tb_jt12_interp_lin;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic signed [11:0] d2_din, d5_din;
    logic               d2_valid, d5_valid;
    logic signed [11:0] d2_dout, d5_dout;
    logic               d2_busy, d5_busy, d2_early, d5_early;

    jt12_interp_lin #(.width(12), .rate_w(2)) dut2 (
        .clk(clk), .rst(rst), .din(d2_din), .din_valid(d2_valid),
        .dout(d2_dout), .busy(d2_busy), .early(d2_early)
    );

    jt12_interp_lin #(.width(12), .rate_w(5)) dut5 (
        .clk(clk), .rst(rst), .din(d5_din), .din_valid(d5_valid),
        .dout(d5_dout), .busy(d5_busy), .early(d5_early)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: after k of N steps from s toward t, dout = floor((s*N + k*(t-s)) / N).
    int  mn[2] = '{4, 32};
    int  m_s[2], m_t[2], m_k[2], m_dout[2];
    bit  m_busy[2], m_early[2];

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_step(input int i, input bit v, input int d);
        if (rst) begin
            m_s[i] = 0; m_t[i] = 0; m_k[i] = 0; m_dout[i] = 0;
            m_busy[i] = 1'b0; m_early[i] = 1'b0;
        end else if (v) begin
            m_early[i] = m_busy[i];
            m_s[i] = m_dout[i];
            m_t[i] = d;
            m_k[i] = 1;
            m_busy[i] = 1'b1;
            m_dout[i] = fdiv(m_s[i] * mn[i] + (m_t[i] - m_s[i]), mn[i]);
        end else begin
            m_early[i] = 1'b0;
            if (m_busy[i]) begin
                m_k[i]++;
                m_dout[i] = fdiv(m_s[i] * mn[i] + m_k[i] * (m_t[i] - m_s[i]), mn[i]);
                if (m_k[i] == mn[i]) m_busy[i] = 1'b0;
            end
        end
        assert (m_dout[i] >= -2048 && m_dout[i] <= 2047);
    endtask

    always @(posedge clk) begin
        model_step(0, d2_valid, int'(d2_din));
        model_step(1, d5_valid, int'(d5_din));
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("r2_dout",  int'(d2_dout),  m_dout[0]);
            chk("r2_busy",  int'(d2_busy),  int'(m_busy[0]));
            chk("r2_early", int'(d2_early), int'(m_early[0]));
            chk("r5_dout",  int'(d5_dout),  m_dout[1]);
            chk("r5_busy",  int'(d5_busy),  int'(m_busy[1]));
            chk("r5_early", int'(d5_early), int'(m_early[1]));
        end
    end

    task automatic clk1();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic strobe2(input int v);
        d2_din = 12'(v);
        d2_valid = 1'b1;
        clk1();
        d2_valid = 1'b0;
    endtask

    // Check a sequence of dout values after a strobe, first value right after the strobe edge.
    task automatic ramp2(input string name, input int v, input int e0, input int e1,
                         input int e2, input int e3);
        int exp_seq[4];
        exp_seq = '{e0, e1, e2, e3};
        strobe2(v);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) clk1();
            chk(name, int'(d2_dout), exp_seq[k]);
            chk({name, "_busy"}, int'(d2_busy), (k < 3) ? 1 : 0);
        end
    endtask

    initial begin
        int prev;
        rst = 1'b1;
        d2_din = '0; d5_din = '0; d2_valid = 1'b0; d5_valid = 1'b0;
        repeat (3) clk1();
        rst = 1'b0;
        clk1();
        chk_en = 1'b1;
        chk("rst_dout", int'(d2_dout), 0);
        chk("rst_busy", int'(d2_busy), 0);
        chk("rst_early", int'(d2_early), 0);

        ramp2("up100", 100, 25, 50, 75, 100);
        for (int k = 0; k < 20; k++) begin
            clk1();
            chk("hold100", int'(d2_dout), 100);
        end

        ramp2("dn100", -100, 50, 0, -50, -100);
        chk("dn100_early", int'(d2_early), 0);
        ramp2("to0", 0, -75, -50, -25, 0);
        ramp2("up3", 3, 0, 1, 2, 3);
        ramp2("back0", 0, 2, 1, 0, 0);
        ramp2("dn3", -3, -1, -2, -3, -3);
        ramp2("back0b", 0, -3, -2, -1, 0);

        strobe2(100);
        chk("cut_a", int'(d2_dout), 25);
        clk1();
        chk("cut_b", int'(d2_dout), 50);
        strobe2(0);
        chk("cut_early", int'(d2_early), 1);
        chk("cut_c", int'(d2_dout), 37);
        clk1();
        chk("cut_early_off", int'(d2_early), 0);
        chk("cut_d", int'(d2_dout), 25);
        clk1();
        chk("cut_e", int'(d2_dout), 12);
        clk1();
        chk("cut_f", int'(d2_dout), 0);
        chk("cut_busy", int'(d2_busy), 0);

        // Strobe on the ramp's final edge: the new ramp wins.
        strobe2(100);
        clk1();
        clk1();
        strobe2(-20);
        chk("last_edge_early", int'(d2_early), 1);
        chk("last_edge_busy", int'(d2_busy), 1);
        repeat (4) clk1();
        chk("last_edge_end", int'(d2_dout), -20);

        // Normal start right after completion.
        strobe2(0);
        repeat (3) clk1();
        strobe2(40);
        chk("after_done_early", int'(d2_early), 0);
        repeat (4) clk1();

        // Reset mid-ramp with a strobe on the same edge.
        strobe2(100);
        clk1();
        rst = 1'b1;
        d2_din = 12'(50);
        d2_valid = 1'b1;
        clk1();
        rst = 1'b0;
        d2_valid = 1'b0;
        chk("rstmid_dout", int'(d2_dout), 0);
        chk("rstmid_busy", int'(d2_busy), 0);
        chk("rstmid_early", int'(d2_early), 0);
        ramp2("post_rst", 100, 25, 50, 75, 100);

        // Full-scale swing at the default ratio.
        d5_din = 12'sd2047;
        d5_valid = 1'b1;
        clk1();
        d5_valid = 1'b0;
        repeat (40) clk1();
        chk("r5_top", int'(d5_dout), 2047);
        d5_din = -12'sd2048;
        d5_valid = 1'b1;
        prev = int'(d5_dout);
        clk1();
        d5_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) clk1();
            chk("r5_mono", (int'(d5_dout) < prev) ? 1 : 0, 1);
            prev = int'(d5_dout);
        end
        chk("r5_bottom", int'(d5_dout), -2048);
        chk("r5_bottom_busy", int'(d5_busy), 0);

        // Random stimulus on both instances, model-checked every clock.
        for (int c = 0; c < 4000; c++) begin
            d2_valid = ($urandom_range(0, 5) == 0);
            d5_valid = ($urandom_range(0, 30) == 0);
            case ($urandom_range(0, 3))
                0: d2_din = 12'sd2047;
                1: d2_din = -12'sd2048;
                default: d2_din = 12'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: d5_din = 12'sd2047;
                1: d5_din = -12'sd2048;
                default: d5_din = 12'($urandom);
            endcase
            rst = ($urandom_range(0, 999) == 0);
            clk1();
        end
        rst = 1'b0;
        d2_valid = 1'b0;
        d5_valid = 1'b0;
        repeat (40) clk1();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
